param_seq_shifter: RTL
======================

PARAM_SEQ_SHIFTER -- requirements
Module: param_seq_shifter

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; legal values are powers of two from 4 to 64.
REQ-002 Parameter AMT_W, default 3, shift-amount width; it SHALL equal clog2(WIDTH).
REQ-003 Parameter STEP, default 1, maximum bit positions shifted per cycle; legal values are 1, 2 and 4, with STEP <= WIDTH.
REQ-004 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1, synchronous active-low reset.
REQ-006 Port start, input, 1, request to begin an operation; sampled on the rising edge.
REQ-007 Port ctrl, input, 3, operation select: 000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 ROL, 101-111 illegal.
REQ-008 Port shift_amt, input, AMT_W, shift distance 0..WIDTH-1.
REQ-009 Port data_in, input, WIDTH, operand.
REQ-010 Port data_out, output, WIDTH, registered result.
REQ-011 Port carry_out, output, 1, last bit shifted or rotated out.
REQ-012 Port busy, output, 1, high while an operation is in progress.
REQ-013 Port done, output, 1, one-cycle completion pulse.
REQ-014 Port err, output, 1, illegal-ctrl flag; valid while done=1.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE; all outputs are registered.
REQ-016 A start sampled high in IDLE or DONE SHALL be accepted: latch data_in, ctrl and shift_amt, load counter = shift_amt.
  - Next state SHIFT if shift_amt != 0 and ctrl is legal.
  - Next state DONE otherwise.
REQ-017 A start sampled high in SHIFT SHALL be ignored, with no effect on the operation in progress.
REQ-018 In SHIFT, each edge SHALL shift the working register by k = min(STEP, counter) positions and set counter -= k.
REQ-019 On the SHIFT edge where counter reaches 0, the FSM SHALL move to DONE.
REQ-020 Latency: for shift_amt = N > 0, done SHALL be high in the cycle after edge k + ceil(N/STEP), where k is the accept edge.
REQ-021 For N = 0 or an illegal ctrl, done SHALL be high in the cycle after edge k.
REQ-022 The FSM SHALL hold DONE for exactly one cycle, then go to IDLE, unless a start is accepted in DONE (back-to-back operation).
REQ-023 busy SHALL be 1 exactly while the state is SHIFT; done SHALL be 1 exactly while the state is DONE.
REQ-024 Shift fill rules:
  - LSL and LSR fill with 0.
  - ASR fills with the original bit WIDTH-1.
  - ROR and ROL wrap the bits around.
REQ-025 data_out SHALL update only on entry to DONE and SHALL hold until the next DONE; intermediate values SHALL NOT appear on data_out.
REQ-026 carry_out SHALL be updated with data_out and SHALL hold the last bit that left the MSB (LSL/ROL) or the LSB (LSR/ASR/ROR).
REQ-027 carry_out SHALL be 0 when N = 0.
REQ-028 For an illegal ctrl, err SHALL be 1, data_out SHALL equal data_in and carry_out SHALL be 0; err SHALL be 0 for every legal operation.

Reset
REQ-029 When rst = 0 at a rising edge, the state SHALL go to IDLE and data_out, carry_out, busy, done, err and the counter SHALL all be 0.
REQ-030 A reset mid-operation SHALL abort the operation with no done pulse; start SHALL be ignored while rst = 0.
REQ-031 The first start after rst returns to 1 SHALL be accepted normally.

Verification
REQ-032 WIDTH=8, STEP=1, data_in=10110011 (one operation per row):

| ctrl | shift_amt | data_out | carry_out | done |
|---|---|---|---|---|
| 000 | 1 | 01100110 | 1 | 2nd cycle after accept |
| 001 | 2 | 00101100 | 1 | — |
| 010 | 3 | 11110110 | 0 | — |
| 011 | 4 | 00111011 | 0 | — |
| 100 | 3 | 10011101 | 1 | — |

REQ-033 shift_amt=0, data_in=0xA5: done in the cycle after accept, data_out=0xA5, carry_out=0, busy never 1.
REQ-034 ctrl=101, data_in=0x3C: done and err both 1 in the cycle after accept, data_out=0x3C.
REQ-035 ROR 5 on 0x81 with a second start (LSL 1, 0xFF) pulsed mid-SHIFT: exactly one done, data_out=0x0C, second request ignored.
REQ-036 WIDTH=16, STEP=2, LSL 5 on 0x0001: busy for 3 cycles, data_out=0x0020, carry_out=0.
REQ-037 rst driven low during SHIFT of an ASR 7: the next edge gives all outputs 0 and no done; a new LSR 1 on 0x02 then yields data_out=0x01.

Source files
------------

// File: rtl/param_seq_shifter_if.sv
// rtl/param_seq_shifter_if.sv - request/result bundle for the sequential shifter
interface param_seq_shifter_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             start;
    logic [2:0]       ctrl;
    logic [AMT_W-1:0] shift_amt;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             carry_out;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, ctrl, shift_amt, data_in,
        input  data_out, carry_out, busy, done, err
    );

    modport slave (
        input  start, ctrl, shift_amt, data_in,
        output data_out, carry_out, busy, done, err
    );
endinterface

// File: rtl/param_seq_shifter.sv
// rtl/param_seq_shifter.sv - multi-cycle shifter/rotator moving up to STEP bits per clock
module param_seq_shifter #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    param_seq_shifter_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [2:0]     OP_LSL = 3'd0;
    localparam logic [2:0]     OP_LSR = 3'd1;
    localparam logic [2:0]     OP_ASR = 3'd2;
    localparam logic [2:0]     OP_ROR = 3'd3;
    localparam logic [2:0]     OP_ROL = 3'd4;
    localparam logic [AMT_W:0] STEP_L = (AMT_W + 1)'(STEP);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             carry_out_q, carry_out_d;
    logic             err_q, err_d;

    logic [AMT_W:0]   k;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;
    logic             legal;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            work_q      <= '0;
            data_out_q  <= '0;
            carry_out_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            work_q      <= work_d;
            data_out_q  <= data_out_d;
            carry_out_q <= carry_out_d;
            err_q       <= err_d;
        end
    end

    // One clock applies k single-bit moves; last_bit tracks the final bit to leave.
    always_comb begin
        k        = ({1'b0, cnt_q} < STEP_L) ? {1'b0, cnt_q} : STEP_L;
        shifted  = work_q;
        last_bit = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if ((AMT_W + 1)'(i) < k) begin
                case (op_q)
                    OP_LSL: begin
                        last_bit = shifted[WIDTH-1];
                        shifted  = {shifted[WIDTH-2:0], 1'b0};
                    end
                    OP_LSR: begin
                        last_bit = shifted[0];
                        shifted  = {1'b0, shifted[WIDTH-1:1]};
                    end
                    OP_ASR: begin
                        last_bit = shifted[0];
                        shifted  = {shifted[WIDTH-1], shifted[WIDTH-1:1]};
                    end
                    OP_ROR: begin
                        last_bit = shifted[0];
                        shifted  = {shifted[0], shifted[WIDTH-1:1]};
                    end
                    OP_ROL: begin
                        last_bit = shifted[WIDTH-1];
                        shifted  = {shifted[WIDTH-2:0], shifted[WIDTH-1]};
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        work_d      = work_q;
        data_out_d  = data_out_q;
        carry_out_d = carry_out_q;
        err_d       = err_q;
        legal       = (bus.ctrl <= OP_ROL);
        case (state_q)
            S_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - k[AMT_W-1:0];
                if (k == {1'b0, cnt_q}) begin
                    state_d     = S_DONE;
                    data_out_d  = shifted;
                    carry_out_d = last_bit;
                    err_d       = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    op_d   = bus.ctrl;
                    work_d = bus.data_in;
                    cnt_d  = bus.shift_amt;
                    if (legal && (bus.shift_amt != '0)) begin
                        state_d = S_SHIFT;
                    end else begin
                        // Zero-distance and illegal requests finish immediately with the operand unchanged.
                        state_d     = S_DONE;
                        data_out_d  = bus.data_in;
                        carry_out_d = 1'b0;
                        err_d       = !legal;
                    end
                end
            end
        endcase
    end

    always_comb begin
        bus.busy      = (state_q == S_SHIFT);
        bus.done      = (state_q == S_DONE);
        bus.data_out  = data_out_q;
        bus.carry_out = carry_out_q;
        bus.err       = err_q;
    end
endmodule
